// File: rtl/local_branch_pred_pkg.sv
// Shared types and constants for the local-history branch predictor.
//   - table geometry (BHT index width, history width, PC bits into the PHT index)
//   - 2-bit PHT counter encodings and reset value
//   - snap_t: lookup snapshot carried from Decode through Execute to Memory
//   - sat_inc: saturating increment for the 32-bit debug counters
package local_branch_pred_pkg;

  localparam int unsigned BHT_IDX_BITS = 6;
  localparam int unsigned HIST_BITS    = 4;
  localparam int unsigned PHT_PC_BITS  = 2;
  localparam int unsigned PHT_IDX_BITS = HIST_BITS + PHT_PC_BITS;
  localparam int unsigned BHT_ENTRIES  = 1 << BHT_IDX_BITS;
  localparam int unsigned PHT_ENTRIES  = 1 << PHT_IDX_BITS;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned CNT_W        = 32;

  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] CTR_RESET = WNT;

  typedef struct packed {
    logic                    valid;
    logic                    pred;
    logic [BHT_IDX_BITS-1:0] bidx;
    logic [HIST_BITS-1:0]    hist;
    logic [PHT_IDX_BITS-1:0] pidx;
  } snap_t;

  // Increment by one when en is set, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/local_branch_pred_if.sv
// Pipeline-facing signal bundle of the branch predictor.
//   master: datapath side (drives PC/branch/flush/outcome, receives predictions)
//   slave : predictor side
interface local_branch_pred_if;
  import local_branch_pred_pkg::*;

  logic [PC_W-1:0]  pcD;
  logic             branchD;
  logic             flushE;
  logic             flushM;
  logic             actual_takeM;
  logic             pred_takeD;
  logic             pred_takeM;
  logic             branchM;
  logic             pred_wrongM;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pcD, branchD, flushE, flushM, actual_takeM,
    input  pred_takeD, pred_takeM, branchM, pred_wrongM, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pcD, branchD, flushE, flushM, actual_takeM,
    output pred_takeD, pred_takeM, branchM, pred_wrongM, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/local_branch_pred_sat_counter2.sv
// 2-bit saturating up/down counter next-state function (purely combinational).
//   i_ctr    : current counter value
//   i_inc    : 1 = count up (taken), 0 = count down (not taken)
//   o_next_c : next counter value, saturating at ST / SNT
module sat_counter2
  import local_branch_pred_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_next_c
);

  always_comb begin
    o_next_c = i_ctr;
    if (i_inc) begin
      if (i_ctr != ST) o_next_c = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_next_c = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/local_branch_pred.sv
// Local-history branch predictor for the 5-stage pipeline.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of local_branch_pred_if
//          in : pcD, branchD, flushE, flushM, actual_takeM
//          out: pred_takeD (combinational), pred_takeM, branchM,
//               pred_wrongM (combinational on actual_takeM), branch_cnt, mispred_cnt
// Decode looks up BHT then PHT with write-through from the Memory-stage update;
// the lookup snapshot rides D->E->M and retrains both tables when it reaches M.
module local_branch_pred
  import local_branch_pred_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  local_branch_pred_if.slave  bus
);

  logic [HIST_BITS-1:0] r_bht [BHT_ENTRIES];
  logic [1:0]           r_pht [PHT_ENTRIES];
  snap_t                r_snap_e;
  snap_t                r_snap_m;
  logic [CNT_W-1:0]     r_branch_cnt;
  logic [CNT_W-1:0]     r_mispred_cnt;

  logic [BHT_IDX_BITS-1:0] w_bidx_d;
  logic [HIST_BITS-1:0]    w_hist_d;
  logic [PHT_IDX_BITS-1:0] w_pidx_d;
  logic [1:0]              w_ctr_d;
  logic                    w_pred_d;
  logic [HIST_BITS-1:0]    w_hist_upd;
  logic [1:0]              w_ctr_upd;
  logic [1:0]              w_ctr_byp;
  logic                    w_upd_m;
  logic                    w_wrong_m;
  snap_t                   w_snap_d;
  logic                    w_unused_pc;

  // Only pcD[BHT_IDX_BITS+1:2] takes part in indexing.
  assign w_unused_pc = ^{bus.pcD[PC_W-1:BHT_IDX_BITS+2], bus.pcD[1:0]};

  assign w_upd_m    = r_snap_m.valid;
  assign w_hist_upd = {r_snap_m.hist[HIST_BITS-2:0], bus.actual_takeM};
  assign w_wrong_m  = r_snap_m.valid & (r_snap_m.pred != bus.actual_takeM);

  // Trained counter for the M-stage entry.
  sat_counter2 u_ctr_upd (
    .i_ctr    (r_pht[r_snap_m.pidx]),
    .i_inc    (bus.actual_takeM),
    .o_next_c (w_ctr_upd)
  );

  // Trained value of the entry Decode is reading; only used when the indices collide.
  sat_counter2 u_ctr_byp (
    .i_ctr    (r_pht[w_pidx_d]),
    .i_inc    (bus.actual_takeM),
    .o_next_c (w_ctr_byp)
  );

  // Decode lookup with write-through from the same-cycle M update.
  always_comb begin
    w_bidx_d = bus.pcD[BHT_IDX_BITS+1:2];
    w_hist_d = r_bht[w_bidx_d];
    if (w_upd_m && (r_snap_m.bidx == w_bidx_d)) w_hist_d = w_hist_upd;
    w_pidx_d = {bus.pcD[PHT_PC_BITS+1:2], w_hist_d};
    w_ctr_d  = r_pht[w_pidx_d];
    if (w_upd_m && (r_snap_m.pidx == w_pidx_d)) w_ctr_d = w_ctr_byp;
    w_pred_d = bus.branchD & w_ctr_d[1];
  end

  assign w_snap_d = '{valid: bus.branchD, pred: w_pred_d, bidx: w_bidx_d,
                      hist: w_hist_d, pidx: w_pidx_d};

  // Branch history table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) r_bht[BHT_IDX_BITS'(i)] <= '0;
    end else if (w_upd_m) begin
      r_bht[r_snap_m.bidx] <= w_hist_upd;
    end
  end

  // Pattern history table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) r_pht[PHT_IDX_BITS'(i)] <= CTR_RESET;
    end else if (w_upd_m) begin
      r_pht[r_snap_m.pidx] <= w_ctr_upd;
    end
  end

  // Snapshot pipe; the M update above still uses the old r_snap_m on a flushM edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap_e <= '0;
      r_snap_m <= '0;
    end else begin
      r_snap_e <= bus.flushE ? '0 : w_snap_d;
      r_snap_m <= bus.flushM ? '0 : r_snap_e;
    end
  end

  // Debug counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd_m) begin
      r_branch_cnt  <= sat_inc(r_branch_cnt, 1'b1);
      r_mispred_cnt <= sat_inc(r_mispred_cnt, w_wrong_m);
    end
  end

  assign bus.pred_takeD  = w_pred_d;
  assign bus.pred_takeM  = r_snap_m.pred;
  assign bus.branchM     = r_snap_m.valid;
  assign bus.pred_wrongM = w_wrong_m;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_local_branch_pred.sv
module tb_local_branch_pred;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  local_branch_pred_if bus();

  local_branch_pred dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tables as plain integer arrays, branches in flight as records.
  typedef struct {
    bit          v;
    bit          pred;
    logic [31:0] pc;
    int          hist;
  } rec_t;

  int   m_bht [64];
  int   m_pht [64];
  int   nx_bht [64];
  int   nx_pht [64];
  rec_t e_rec;
  rec_t m_rec;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  logic        s_pred_d, s_bm, s_pm, s_wrong;
  logic [31:0] s_bcnt, s_mcnt;

  typedef struct {
    logic [31:0] pc;
    bit          act;
    bit          pd;
    bit          bm;
    bit          pm;
    bit          wr;
    logic [31:0] bc;
    logic [31:0] mc;
  } vec_t;
  vec_t vt [10];

  bit sat_pred [10];

  function automatic int bidx_of(logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic int pidx_of(logic [31:0] pc, int h);
    return int'(pc[3:2]) * 16 + h;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_bht[i] = 0;
      m_pht[i] = 1;
    end
    e_rec  = '{v: 1'b0, pred: 1'b0, pc: 32'h0, hist: 0};
    m_rec  = '{v: 1'b0, pred: 1'b0, pc: 32'h0, hist: 0};
    exp_bc = 32'h0;
    exp_mc = 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit br, input bit fe, input bit fm, input bit act);
    bus.pcD          = pc;
    bus.branchD      = br;
    bus.flushE       = fe;
    bus.flushM       = fm;
    bus.actual_takeM = act;
  endtask

  task automatic sample();
    s_pred_d = bus.pred_takeD;
    s_bm     = bus.branchM;
    s_pm     = bus.pred_takeM;
    s_wrong  = bus.pred_wrongM;
    s_bcnt   = bus.branch_cnt;
    s_mcnt   = bus.mispred_cnt;
  endtask

  // One clock cycle: drive after negedge, check 1 time unit before posedge, advance model.
  task automatic cycle(input logic [31:0] pc, input bit br, input bit fe, input bit fm, input bit act);
    bit exp_pred;
    bit exp_wrong;
    int h;
    int c;
    @(negedge clk);
    drive(pc, br, fe, fm, act);
    nx_bht = m_bht;
    nx_pht = m_pht;
    if (m_rec.v) begin
      nx_bht[bidx_of(m_rec.pc)] = (m_rec.hist * 2 + int'(act)) % 16;
      c = m_pht[pidx_of(m_rec.pc, m_rec.hist)];
      nx_pht[pidx_of(m_rec.pc, m_rec.hist)] = act ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    end
    h         = nx_bht[bidx_of(pc)];
    c         = nx_pht[pidx_of(pc, h)];
    exp_pred  = br && (c >= 2);
    exp_wrong = m_rec.v && (m_rec.pred != act);
    #4;
    sample();
    chk("pred_takeD",  32'(s_pred_d), 32'(exp_pred));
    chk("branchM",     32'(s_bm),     32'(m_rec.v));
    chk("pred_takeM",  32'(s_pm),     32'(m_rec.pred));
    chk("pred_wrongM", 32'(s_wrong),  32'(exp_wrong));
    chk("branch_cnt",  s_bcnt,        exp_bc);
    chk("mispred_cnt", s_mcnt,        exp_mc);
    @(posedge clk);
    m_bht = nx_bht;
    m_pht = nx_pht;
    if (m_rec.v) begin
      if (exp_bc != 32'hFFFF_FFFF) exp_bc++;
      if (exp_wrong && (exp_mc != 32'hFFFF_FFFF)) exp_mc++;
    end
    m_rec = fm ? '{v: 1'b0, pred: 1'b0, pc: 32'h0, hist: 0} : e_rec;
    e_rec = fe ? '{v: 1'b0, pred: 1'b0, pc: 32'h0, hist: 0}
               : '{v: br, pred: exp_pred, pc: pc, hist: h};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_branchM"},     32'(bus.branchM),     32'h0);
    chk({tag, "_pred_takeM"},  32'(bus.pred_takeM),  32'h0);
    chk({tag, "_pred_wrongM"}, 32'(bus.pred_wrongM), 32'h0);
    chk({tag, "_branch_cnt"},  bus.branch_cnt,       32'h0);
    chk({tag, "_mispred_cnt"}, bus.mispred_cnt,      32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // T,T,N training on pc 0x40, one branch every other cycle so each lookup
    // meets the previous branch's update in the same cycle.
    vt[0] = '{32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vt[1] = '{32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0};
    vt[2] = '{32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd1};
    vt[3] = '{32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2};
    vt[4] = '{32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd2};
    vt[5] = '{32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd3};
    vt[6] = '{32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd4};
    vt[7] = '{32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd6, 32'd4};
    vt[8] = '{32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd7, 32'd4};
    vt[9] = '{32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8, 32'd4};

    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].pc, 1'b1, 1'b0, 1'b0, vt[i].act);
      chk($sformatf("tbl%0d_pred_d", i),  32'(s_pred_d), 32'(vt[i].pd));
      chk($sformatf("tbl%0d_branchM", i), 32'(s_bm),     32'(vt[i].bm));
      chk($sformatf("tbl%0d_pred_m", i),  32'(s_pm),     32'(vt[i].pm));
      chk($sformatf("tbl%0d_wrong", i),   32'(s_wrong),  32'(vt[i].wr));
      chk($sformatf("tbl%0d_bcnt", i),    s_bcnt,        vt[i].bc);
      chk($sformatf("tbl%0d_mcnt", i),    s_mcnt,        vt[i].mc);
      cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_idle_bm", i), 32'(s_bm), 32'h0);
    end

    // Async reset between edges while the last trained branch sits in M.
    @(negedge clk);
    drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("pre_async_branchM", 32'(bus.branchM),    32'h1);
    chk("pre_async_pred_d",  32'(bus.pred_takeD), 32'h1);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("async");
    chk("async_pred_d", 32'(bus.pred_takeD), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_async_pred_d", 32'(s_pred_d), 32'h0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_async_bcnt", s_bcnt, 32'd1);

    // Flush handling.
    do_reset();
    cycle(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flushE_branchM", 32'(s_bm), 32'h0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flushE_bcnt", s_bcnt, 32'h0);
    cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flushM_branchM", 32'(s_bm), 32'h0);
    cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flushM_upd_branchM", 32'(s_bm), 32'h1);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flushM_upd_bcnt", s_bcnt, 32'h1);
    cycle(32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h48, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_both_bm1", 32'(s_bm), 32'h0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_both_bm2", 32'(s_bm), 32'h0);
    chk("flush_both_bcnt", s_bcnt, 32'h1);

    // Counter saturation on PHT index {00,1111}.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      sat_pred[k] = s_pred_d;
      cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("sat_pred%0d", k), 32'(sat_pred[k]), (k >= 5) ? 32'h1 : 32'h0);
    for (int j = 0; j < 5; j++) begin
      cycle(32'hC0, 1'b1, 1'b0, 1'b0, (j == 0) ? 1'b0 : 1'b1);
      if (j == 4) chk("sat_after_dec_pred", 32'(s_pred_d), 32'h1);
      cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with heavy aliasing.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      case ($urandom_range(0, 6))
        0: pc = 32'h40;
        1: pc = 32'h44;
        2: pc = 32'h80;
        3: pc = 32'h100;
        4: pc = 32'h140;
        5: pc = 32'hC4;
        default: pc = $urandom & 32'h0000_FFFC;
      endcase
      cycle(pc, ($urandom % 10) < 7, ($urandom % 10) == 0,
            ($urandom % 12) == 0, ($urandom % 10) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
